shift_reg_univ_burst: RTL and testbench
=======================================

// Module: shift_reg_univ_burst
// PURPOSE
//  Parametrised universal shift register. Successor to the fixed 32-bit shift/rotate/load register.
//  Adds per-step shift distance, an arithmetic-shift mode, and a burst engine that runs N steps
//  from one start pulse, with busy/done handshake. Used as a datapath shifter/serialiser by controllers.
// PARAMETERS
//  WIDTH   32              register width, >=2
//  AMT_W   $clog2(WIDTH)   width of amt
//  CNT_W   8               width of burst_len
// PORTS
//  clk        in   1       single clock, rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  enb        in   1       step enable; in RUN, a low enb stalls the burst
//  dir        in   1       0 = left (toward MSB), 1 = right
//  mode       in   2       00 shift (s_in fill), 01 rotate, 10 parallel load, 11 arithmetic shift
//  s_in       in   1       serial fill bit for mode 00; sampled live at every step
//  amt        in   AMT_W  step distance; 0 = hold q; values >=WIDTH clamp to WIDTH-1
//  d          in   WIDTH  parallel load data
//  start      in   1       begin burst (IDLE only)
//  burst_len  in   CNT_W  number of steps in a burst
//  q          out  WIDTH  register contents
//  s_out      out  1       last bit shifted out by the latest step
//  busy       out  1       burst in progress
//  done       out  1       one-cycle pulse at burst end
// BEHAVIOUR
//  - Reset (async assert, clk-synchronous release) sets q=0, s_out=0, busy=0, done=0, state=IDLE, count=0.
//    Reset during a burst aborts it. No done pulse is produced.
//  - Step op, for distance k=amt:
//    00: left  q<={q[W-1-k:0], {k{s_in}}}; right q<={{k{s_in}}, q[W-1:k]}.
//    01: rotate by k in dir.
//    10: q<=d, s_out<=0.
//    11: left fills 0 (s_in ignored); right fills q[W-1] (sign).
//    s_out is set to the last bit leaving: left q[W-k], right q[k-1]. For rotate, it is the same wrapped bit.
//    If k=0: q and s_out hold.
//  - IDLE, enb=1, start=0: apply one step per edge using live mode/dir/amt/d (legacy behaviour).
//  - IDLE, enb=0: hold.
//  - IDLE, start=1 (enb ignored): latch mode, dir, amt, d, burst_len. q is unchanged this edge.
//    If burst_len=0: done=1 next cycle, stay IDLE, busy stays 0.
//    Otherwise: busy<=1, count<=burst_len, go to RUN.
//    For mode 10, count is forced to 1.
//  - RUN: each edge with enb=1 applies one step with the latched controls and live s_in, then count--.
//    On the edge where count reaches 0: busy<=0, done<=1 for exactly one cycle, return to IDLE.
//    On edges with enb=0: no step, count holds.
//    q shows the final value in the same cycle that done is high.
//  - start while busy=1 is ignored. Live mode/dir/amt/d changes during RUN are ignored.
//  - Latency: a burst of N steps with no stalls has busy high for N cycles, and done follows the final step.
// STRUCTURE
//  - Package shreg_pkg: MODE_SHIFT=2'b00, MODE_ROT=2'b01, MODE_LOAD=2'b10, MODE_ASHIFT=2'b11;
//    state encoding ST_IDLE/ST_RUN.
//  - Sub-module shreg_step (combinational): inputs q, mode, dir, amt, s_in, d; outputs next_q, next_sout.
//  - Top level holds the FSM, the counter, and the latched-control registers.
// TESTING (WIDTH=32)
//  1. rst_n low mid-burst (len=5, after 2 steps) -> q=0, busy=0 immediately.
//     No done. Next start works normally.
//  2. Load d=32'h1, then 32 single steps mode=01 dir=0 amt=1 -> q=32'h1 again.
//     s_out=1 only on the 32nd step.
//  3. Load 32'h8000_0000; start mode=11 dir=1 amt=4 len=3 -> q 0xF800_0000, 0xFF80_0000, 0xFFF8_0000.
//     busy 3 cycles, done 1 cycle.
//  4. q=32'h1234_5678; single step mode=00 dir=0 amt=8 s_in=1 -> q=32'h3456_78FF, s_out=0.
//  5. Burst len=4 with enb low for 2 cycles mid-burst -> exactly 4 steps, busy 6 cycles.
//     A start pulsed while busy is ignored.
//  6. start with burst_len=0 -> done pulses next cycle, busy stays 0, q unchanged.
//     amt=0 single step -> q and s_out hold.

Source files
------------

// File: rtl/shreg_pkg.sv
// Shared constants for the universal burst shift register: step modes and FSM states.
package shreg_pkg;

   localparam logic [1:0] MODE_SHIFT  = 2'b00;
   localparam logic [1:0] MODE_ROT    = 2'b01;
   localparam logic [1:0] MODE_LOAD   = 2'b10;
   localparam logic [1:0] MODE_ASHIFT = 2'b11;

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_RUN  = 1'b1;

endpackage

// File: rtl/shreg_step.sv
// One combinational shift/rotate/load step of distance amt (clamped to WIDTH-1).
module shreg_step
   import shreg_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int AMT_W = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] q,
   input  logic [1:0]       mode,
   input  logic             dir,
   input  logic [AMT_W-1:0] amt,
   input  logic             s_in,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] next_q,
   output logic             next_sout
);

   localparam logic [AMT_W:0] KMAX = (AMT_W+1)'(WIDTH-1);

   logic [AMT_W:0]   k;
   logic [WIDTH-1:0] ones, shl, shr, lmask, rmask, wrap_l, wrap_r;
   logic [WIDTH:0]   qx;
   logic             sout_l, sout_r, fill;

   always_comb begin
      k      = ({1'b0, amt} > KMAX) ? KMAX : {1'b0, amt};
      ones   = '1;
      shl    = q << k;
      shr    = q >> k;
      lmask  = ~(ones << k);
      rmask  = ~(ones >> k);
      // Shifting by WIDTH yields 0, so k=0 needs no special case for the wrap terms.
      wrap_l = q >> (WIDTH - int'(k));
      wrap_r = q << (WIDTH - int'(k));
      qx     = {q, 1'b0} >> k;
      sout_l = wrap_l[0];
      sout_r = qx[0];
   end

   always_comb begin
      next_q    = q;
      next_sout = dir ? sout_r : sout_l;
      fill      = s_in;
      case (mode)
         MODE_LOAD: begin
            next_q    = d;
            next_sout = 1'b0;
         end
         MODE_ROT: next_q = dir ? (shr | wrap_r) : (shl | wrap_l);
         default: begin
            if (mode == MODE_ASHIFT) fill = dir ? q[WIDTH-1] : 1'b0;
            next_q = dir ? (shr | (fill ? rmask : '0)) : (shl | (fill ? lmask : '0));
         end
      endcase
   end

endmodule

// File: rtl/shift_reg_univ_burst.sv
// Universal shift register with live single-step operation and a latched-control burst engine.
module shift_reg_univ_burst
   import shreg_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int AMT_W = $clog2(WIDTH),
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enb,
   input  logic             dir,
   input  logic [1:0]       mode,
   input  logic             s_in,
   input  logic [AMT_W-1:0] amt,
   input  logic [WIDTH-1:0] d,
   input  logic             start,
   input  logic [CNT_W-1:0] burst_len,
   output logic [WIDTH-1:0] q,
   output logic             s_out,
   output logic             busy,
   output logic             done
);

   logic             state;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       l_mode;
   logic             l_dir;
   logic [AMT_W-1:0] l_amt;
   logic [WIDTH-1:0] l_d;

   logic             run, do_step, upd_sout, nso;
   logic [1:0]       s_mode;
   logic             s_dir;
   logic [AMT_W-1:0] s_amt;
   logic [WIDTH-1:0] s_d, nq;

   // During a burst the step uses latched controls; s_in stays live either way.
   always_comb begin
      run      = (state == ST_RUN);
      s_mode   = run ? l_mode : mode;
      s_dir    = run ? l_dir  : dir;
      s_amt    = run ? l_amt  : amt;
      s_d      = run ? l_d    : d;
      do_step  = run ? enb : (enb && !start);
      upd_sout = (s_mode == MODE_LOAD) || (s_amt != '0);
   end

   shreg_step #(.WIDTH(WIDTH), .AMT_W(AMT_W)) u_step (
      .q(q), .mode(s_mode), .dir(s_dir), .amt(s_amt), .s_in(s_in), .d(s_d),
      .next_q(nq), .next_sout(nso)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q      <= '0;
         s_out  <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         state  <= ST_IDLE;
         cnt    <= '0;
         l_mode <= MODE_SHIFT;
         l_dir  <= 1'b0;
         l_amt  <= '0;
         l_d    <= '0;
      end else begin
         done <= 1'b0;
         if (do_step) begin
            q <= nq;
            if (upd_sout) s_out <= nso;
         end
         if (!run) begin
            if (start) begin
               l_mode <= mode;
               l_dir  <= dir;
               l_amt  <= amt;
               l_d    <= d;
               if (burst_len == '0) begin
                  done <= 1'b1;
               end else begin
                  state <= ST_RUN;
                  busy  <= 1'b1;
                  // A load is idempotent, so a load burst is a single step.
                  cnt   <= (mode == MODE_LOAD) ? CNT_W'(1) : burst_len;
               end
            end
         end else if (enb) begin
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_shift_reg_univ_burst.sv
// Directed plus randomized bench for shift_reg_univ_burst against a bit-serial reference model.
module tb_shift_reg_univ_burst;

   logic        clk = 1'b0;
   logic        rst_n, enb, dir, s_in, start;
   logic [1:0]  mode;
   logic [4:0]  amt;
   logic [31:0] d, q;
   logic [7:0]  burst_len;
   logic        s_out, busy, done;

   int passed = 0;
   int total  = 0;

   // reference model state
   logic [31:0] mq, ld;
   logic        mso, mrun, mdone, ldir;
   logic [1:0]  lmode;
   logic [4:0]  lamt;
   int          mcnt;

   always #5 clk = ~clk;

   shift_reg_univ_burst #(.WIDTH(32), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .enb(enb), .dir(dir), .mode(mode), .s_in(s_in),
      .amt(amt), .d(d), .start(start), .burst_len(burst_len),
      .q(q), .s_out(s_out), .busy(busy), .done(done)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      assert (act === exp) passed++;
      else $error("FAIL %s: got %h expected %h", tag, act, exp);
   endtask

   // One step of distance k done as k single-bit moves.
   task automatic mstep(input logic [1:0] md, input logic dr, input logic [4:0] am,
                        input logic [31:0] dd, input logic si);
      logic ob, fill;
      if (md == 2'b10) begin
         mq  = dd;
         mso = 1'b0;
      end else begin
         for (int i = 0; i < int'(am); i++) begin
            if (!dr) begin
               ob   = mq[31];
               fill = (md == 2'b01) ? ob : (md == 2'b11) ? 1'b0 : si;
               mq   = {mq[30:0], fill};
            end else begin
               ob   = mq[0];
               fill = (md == 2'b01) ? ob : (md == 2'b11) ? mq[31] : si;
               mq   = {fill, mq[31:1]};
            end
            mso = ob;
         end
      end
   endtask

   task automatic mreset();
      mq = '0; mso = 0; mrun = 0; mdone = 0; mcnt = 0;
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".q"},    q,     mq);
      chk({tag, ".sout"}, 32'(s_out), 32'(mso));
      chk({tag, ".busy"}, 32'(busy),  32'(mrun));
      chk({tag, ".done"}, 32'(done),  32'(mdone));
   endtask

   // Advance the model for the coming edge, take the edge, compare everything.
   task automatic tick(input string tag);
      logic nd;
      nd = 1'b0;
      if (!rst_n) begin
         mreset();
      end else if (!mrun) begin
         if (start) begin
            lmode = mode; ldir = dir; lamt = amt; ld = d;
            if (burst_len == 0) nd = 1'b1;
            else begin
               mrun = 1'b1;
               mcnt = (mode == 2'b10) ? 1 : int'(burst_len);
            end
         end else if (enb) begin
            mstep(mode, dir, amt, d, s_in);
         end
      end else if (enb) begin
         mstep(lmode, ldir, lamt, ld, s_in);
         mcnt--;
         if (mcnt == 0) begin
            mrun = 1'b0;
            nd   = 1'b1;
         end
      end
      if (rst_n) mdone = nd;
      @(posedge clk);
      #1;
      chk_all(tag);
   endtask

   task automatic set_in(input logic e, input logic [1:0] m, input logic dr,
                         input logic [4:0] a, input logic si, input logic [31:0] dd);
      enb = e; mode = m; dir = dr; amt = a; s_in = si; d = dd;
   endtask

   int bcyc;

   initial begin
      rst_n = 0; start = 0; burst_len = 0;
      set_in(0, 2'b00, 0, 5'd0, 0, '0);
      mreset();
      #1;
      chk_all("reset");
      tick("reset_hold");
      rst_n = 1;

      // mid-burst async reset aborts with no done
      set_in(1, 2'b10, 0, 5'd1, 0, 32'hDEAD_BEEF);
      tick("t1.load");
      set_in(1, 2'b00, 0, 5'd3, 1, '0);
      start = 1; burst_len = 8'd5;
      tick("t1.start");
      start = 0;
      tick("t1.s1");
      tick("t1.s2");
      #2 rst_n = 0;
      #1;
      mreset();
      chk({"t1.async.q"}, q, 32'h0);
      chk("t1.async.busy", 32'(busy), 32'h0);
      tick("t1.rst_a");
      tick("t1.rst_b");
      rst_n = 1;
      set_in(1, 2'b01, 1, 5'd4, 0, '0);
      start = 1; burst_len = 8'd2;
      tick("t1.restart");
      start = 0;
      tick("t1.r1");
      tick("t1.r2");
      chk("t1.r2.done", 32'(done), 32'h1);

      // 32 single-bit left rotates return the loaded pattern
      set_in(1, 2'b10, 0, 5'd1, 0, 32'h1);
      tick("t2.load");
      set_in(1, 2'b01, 0, 5'd1, 0, '0);
      for (int i = 0; i < 32; i++) tick("t2.rot");
      chk("t2.q", q, 32'h1);
      chk("t2.sout", 32'(s_out), 32'h1);

      // arithmetic right burst
      set_in(1, 2'b10, 0, 5'd1, 0, 32'h8000_0000);
      tick("t3.load");
      set_in(1, 2'b11, 1, 5'd4, 0, '0);
      start = 1; burst_len = 8'd3;
      tick("t3.start");
      start = 0;
      set_in(1, 2'b00, 0, 5'd9, 1, 32'h5);
      tick("t3.s1");
      chk("t3.s1.q", q, 32'hF800_0000);
      tick("t3.s2");
      chk("t3.s2.q", q, 32'hFF80_0000);
      tick("t3.s3");
      chk("t3.s3.q", q, 32'hFFF8_0000);
      chk("t3.s3.done", 32'(done), 32'h1);
      enb = 0;
      tick("t3.after");

      // left shift by 8 with s_in fill
      set_in(1, 2'b10, 0, 5'd1, 0, 32'h1234_5678);
      tick("t4.load");
      set_in(1, 2'b00, 0, 5'd8, 1, '0);
      tick("t4.shift");
      chk("t4.q", q, 32'h3456_78FF);
      chk("t4.sout", 32'(s_out), 32'h0);

      // stalled burst, start while busy ignored
      set_in(1, 2'b01, 0, 5'd3, 0, '0);
      start = 1; burst_len = 8'd4;
      tick("t5.start");
      start = 0;
      bcyc = 0;
      for (int i = 0; i < 6; i++) begin
         enb   = (i == 2 || i == 3) ? 1'b0 : 1'b1;
         start = (i == 2);
         burst_len = 8'd9;
         if (busy) bcyc++;
         tick("t5.step");
      end
      start = 0;
      chk("t5.busycyc", 32'(bcyc), 32'd6);
      chk("t5.done", 32'(done), 32'h1);
      enb = 0;
      tick("t5.idle");

      // zero-length burst and amt=0 hold
      set_in(0, 2'b00, 1, 5'd5, 1, '0);
      start = 1; burst_len = 8'd0;
      tick("t6.start0");
      start = 0;
      chk("t6.done", 32'(done), 32'h1);
      chk("t6.busy", 32'(busy), 32'h0);
      set_in(1, 2'b00, 0, 5'd0, 1, '0);
      tick("t6.amt0");

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         set_in(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom());
         start     = ($urandom_range(0, 9) == 0);
         burst_len = 8'($urandom_range(0, 6));
         tick("rand");
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
